apb_request_arbiter: RTL and testbench
======================================

Name: apb_request_arbiter

Overview:
- Shares the single processor-side port of APB_Master (addr/wdata/sel/start/stable/rdata) between NUM_REQ requesters, such as bit_cpu and an I2C status poller.
- Arbitrates round-robin and latches the winner's command.
- Issues a one-cycle start pulse to APB_Master, waits for stable, then returns rdata plus an ack/err pulse to the winner.
- Includes a timeout so a hung slave cannot lock the bus.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 8, address width
- DATA_W, 8, data width
- SEL_W, 4, peripheral select width
- TIMEOUT, 64, max cycles in WAIT before aborting; 0 disables the timeout

Ports:
- clk  in  1  system clock, the clock APB_Master's processor side runs on
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester request level; held until ack
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_sel  in  NUM_REQ*SEL_W  packed peripheral selects
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
- err  out  1  valid with ack; 1 = timeout abort
- rdata  out  DATA_W  read data; valid with ack, held until the next ack
- grant  out  NUM_REQ  one-hot current owner; 0 when idle
- busy  out  1  state != IDLE
- m_start  out  1  start pulse to APB_Master
- m_write  out  1  direction to APB_Master
- m_addr  out  ADDR_W  address to APB_Master
- m_wdata  out  DATA_W  write data to APB_Master
- m_sel  out  SEL_W  select to APB_Master
- m_stable  in  1  APB_Master transfer-complete indication
- m_rdata  in  DATA_W  APB_Master read data

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - All outputs go to 0, including rdata and grant.
  - Timeout counter goes to 0.
  - last_grant goes to NUM_REQ-1, so requester 0 wins first.
  - Reset during any state aborts the transfer; no ack is issued.
- IDLE:
  - If req != 0, the winner is the first set bit searching upward from last_grant+1, with wrap-around.
  - Register the winner's write/addr/wdata/sel onto the m_* outputs, set grant one-hot, and go to ISSUE.
  - Requests are sampled only in IDLE.
- ISSUE:
  - m_start = 1 for exactly this one cycle.
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - m_start = 0. m_addr/m_wdata/m_sel/m_write are held stable.
  - If m_stable = 1, capture m_rdata into rdata, set err = 0, and go to DONE.
  - Else, if TIMEOUT != 0 and the counter equals TIMEOUT-1, set err = 1, leave rdata unchanged, and go to DONE.
  - Else, increment the counter.
  - m_stable is ignored outside WAIT.
- DONE:
  - ack[owner] = 1 for one cycle.
  - last_grant = owner; grant = 0.
  - Go to IDLE.
  - err stays 0 except during the DONE cycle that follows a timeout.
- Latency:
  - req seen at cycle 0 → m_start at cycle 1.
  - m_stable seen at cycle k → ack at cycle k+1.
  - Back-to-back transactions have a minimum of 4 cycles each.
- Requester rules:
  - Deasserting req before grant drops the request silently.
  - Deasserting req after grant does not cancel: the transfer completes and ack still pulses.
  - A requester's command fields must be stable while req = 1 in IDLE.
  - If req is still high the cycle after ack, a new request is taken, but round-robin favours other pending requesters.
- Simultaneous requests: exactly one grant. There is no starvation; the worst-case wait is NUM_REQ-1 transactions.
- Width rules:
  - The timeout counter is $clog2(TIMEOUT+1) bits wide and saturates.
  - Packed-vector slicing is fixed: requester i occupies slot i.

Decomposition:
- Package apb_arb_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, WAIT, DONE};
  - width constants ADDR_W_DEF, DATA_W_DEF, SEL_W_DEF;
  - function rr_pick(req, last_grant) returning a one-hot vector.
- One sub-module, rr_arbiter: combinational round-robin pick plus the registered last_grant pointer, with an update strobe driven in DONE.

Test Plan:
- Single read: req[0]=1, addr=8'h1F, sel=4'h1, write=0; m_stable 3 cycles after m_start with m_rdata=8'hA5. Required: m_start exactly 1 cycle at cycle 1, m_addr=8'h1F; ack[0] one cycle after stable; rdata=8'hA5; err=0.
- Contention after reset: req=2'b11 held, every transfer completing. Required grant order 0,1,0,1; ack[0] and ack[1] never high together.
- Timeout: TIMEOUT=8, m_stable held 0. Required: ack with err=1 exactly 9 cycles after m_start; rdata keeps its previous value; next request is served normally.
- Withdrawal: req[1] pulsed for 1 cycle while requester 0 is in WAIT. Required: no grant to 1. Separately, req[0] dropped during WAIT: ack[0] still pulses.
- Reset mid-WAIT: rst_n low for 2 cycles. Required: all outputs 0 immediately, with no ack. After release with req=2'b11, requester 0 is granted first.
- Write path: req[1]=1, write=1, wdata=8'h3C, sel=4'h2. Required: m_write=1, m_wdata=8'h3C, m_sel=4'h2 held from ISSUE through WAIT; ack[1] follows.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types, default widths and the round-robin pick function for the
// APB request arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned SEL_W_DEF  = 4;

    // Widest supported requester count; the pick works on vectors of this size.
    localparam int unsigned RR_MAX = 8;

    // One-hot pick of the first set request strictly after last_grant,
    // wrapping within num_req slots. Returns zero when no request is set.
    function automatic logic [RR_MAX-1:0] rr_pick(
        input logic [RR_MAX-1:0] req,
        input logic [2:0]        last_grant,
        input int unsigned       num_req
    );
        logic [RR_MAX-1:0] pick;
        logic              found;
        logic [2:0]        idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned off = 1; off <= RR_MAX; off++) begin
            if (off <= num_req) begin
                idx = 3'((32'(last_grant) + off) % num_req);
                if (!found && req[idx]) begin
                    pick[idx] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/apb_request_arbiter_rr.sv
// Round-robin selector: combinational pick from the current requests and a
// registered pointer to the last served requester, advanced on update.
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    input  logic [NUM_REQ-1:0] owner,
    output logic [NUM_REQ-1:0] pick,
    output logic               pick_valid
);

    logic [2:0]        last_grant_q;
    logic [2:0]        last_grant_d;
    logic [2:0]        owner_idx;
    logic [RR_MAX-1:0] req_ext;
    logic [RR_MAX-1:0] pick_full;

    // Widen the request vector and select the next requester after last_grant.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        pick_full              = rr_pick(req_ext, last_grant_q, NUM_REQ);
        pick                   = pick_full[NUM_REQ-1:0];
        pick_valid             = |pick_full;
    end

    // Encode the finishing owner and move the pointer when the transfer ends.
    always_comb begin
        owner_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner[i]) begin
                owner_idx = 3'(i);
            end
        end
        last_grant_d = update ? owner_idx : last_grant_q;
    end

    // Pointer register; resets to the top slot so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 3'(NUM_REQ - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/apb_request_arbiter.sv
// Shares the processor-side port of APB_Master between NUM_REQ requesters:
// round-robin grant, one-cycle start pulse, wait for stable or timeout,
// then an ack pulse (with err on timeout) back to the owner.
module apb_request_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned SEL_W   = SEL_W_DEF,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      err,
    output logic [DATA_W-1:0]         rdata,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      m_start,
    output logic                      m_write,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W-1:0]         m_wdata,
    output logic [SEL_W-1:0]          m_sel,
    input  logic                      m_stable,
    input  logic [DATA_W-1:0]         m_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                m_write_q, m_write_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic [SEL_W-1:0]    m_sel_q, m_sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  pick;
    logic                pick_valid;
    logic                arb_update;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .update     (arb_update),
        .owner      (grant_q),
        .pick       (pick),
        .pick_valid (pick_valid)
    );

    // Next-state and registered-output logic for the transfer sequence.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        m_write_d  = m_write_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_sel_d    = m_sel_q;
        cnt_d      = cnt_q;
        arb_update = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (pick[i]) begin
                            m_write_d = req_write[i];
                            m_addr_d  = req_addr[i*ADDR_W +: ADDR_W];
                            m_wdata_d = req_wdata[i*DATA_W +: DATA_W];
                            m_sel_d   = req_sel[i*SEL_W +: SEL_W];
                        end
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (m_stable) begin
                    rdata_d = m_rdata;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                err_d      = 1'b0;
                grant_d    = '0;
                arb_update = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            m_write_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_sel_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            m_write_q <= m_write_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_sel_q   <= m_sel_d;
            cnt_q     <= cnt_d;
        end
    end

    assign grant   = grant_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign busy    = (state_q != IDLE);
    assign m_start = (state_q == ISSUE);
    assign ack     = (state_q == DONE) ? grant_q : '0;
    assign m_write = m_write_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_sel   = m_sel_q;

endmodule

// File: tb/tb_apb_request_arbiter.sv
// Bench for apb_request_arbiter: a simple APB_Master stand-in answers each
// start after a programmable delay; completions are checked against a queue
// of expected acks filled as stimulus is issued.
module tb_apb_request_arbiter;

    localparam int unsigned NR = 2;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req;
    logic [1:0]    req_write;
    logic [15:0]   req_addr;
    logic [15:0]   req_wdata;
    logic [7:0]    req_sel;
    logic [1:0]    ack;
    logic          err;
    logic [7:0]    rdata;
    logic [1:0]    grant;
    logic          busy;
    logic          m_start;
    logic          m_write;
    logic [7:0]    m_addr;
    logic [7:0]    m_wdata;
    logic [3:0]    m_sel;
    logic          m_stable;
    logic [7:0]    m_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] ack;
        logic       err;
        logic [7:0] rdata;
    } exp_t;
    exp_t sb[$];

    logic [7:0] mem [256];
    logic [7:0] model_rdata;
    logic       slave_en;
    int         slave_delay;
    int         rem;
    logic [7:0] lat_addr;

    apb_request_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (8),
        .DATA_W  (8),
        .SEL_W   (4),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_sel   (req_sel),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .grant     (grant),
        .busy      (busy),
        .m_start   (m_start),
        .m_write   (m_write),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_sel     (m_sel),
        .m_stable  (m_stable),
        .m_rdata   (m_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int idx, input logic w, input logic [7:0] a,
                           input logic [7:0] wd, input logic [3:0] s);
        req_write[idx]       = w;
        req_addr[idx*8 +: 8] = a;
        req_wdata[idx*8 +: 8] = wd;
        req_sel[idx*4 +: 4]  = s;
    endtask

    // Expected completion; a timeout keeps the previous read data.
    task automatic push_exp(input logic [1:0] a, input logic e, input logic [7:0] addr);
        exp_t x;
        if (!e) model_rdata = mem[addr];
        x.ack   = a;
        x.err   = e;
        x.rdata = model_rdata;
        sb.push_back(x);
    endtask

    // APB_Master stand-in: raise m_stable for one cycle slave_delay cycles after m_start.
    initial begin
        m_stable = 1'b0;
        m_rdata  = '0;
        rem      = 0;
        lat_addr = '0;
        forever begin
            tick();
            m_stable = 1'b0;
            if (!rst_n) begin
                rem = 0;
            end else begin
                if (rem > 0) begin
                    rem = rem - 1;
                    if (rem == 0) begin
                        m_stable = 1'b1;
                        m_rdata  = mem[lat_addr];
                    end
                end
                if (m_start === 1'b1 && slave_en) begin
                    rem      = slave_delay;
                    lat_addr = m_addr;
                end
            end
        end
    end

    // Scoreboard: every ack pops and compares one expected completion.
    initial begin
        exp_t e;
        forever begin
            tick();
            checks++;
            if (ack !== 2'b00) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_ack: ack=%b err=%b, required no ack", ack, err);
                end else begin
                    e = sb.pop_front();
                    if (ack !== e.ack || err !== e.err || rdata !== e.rdata) begin
                        errors++;
                        $display("FAIL sb_ack: ack=%b err=%b rdata=%h, required ack=%b err=%b rdata=%h",
                                 ack, err, rdata, e.ack, e.err, e.rdata);
                    end
                end
            end else if (err !== 1'b0) begin
                errors++;
                $display("FAIL err_without_ack: err=%b, required 0", err);
            end
        end
    end

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({ack, err, rdata, grant, busy, m_start} !== '0) begin
            errors++;
            $display("FAIL reset_status: ack=%b err=%b rdata=%h grant=%b busy=%b m_start=%b, required all 0",
                     ack, err, rdata, grant, busy, m_start);
        end
        checks++;
        if ({m_write, m_addr, m_wdata, m_sel} !== '0) begin
            errors++;
            $display("FAIL reset_cmd: m_write=%b m_addr=%h m_wdata=%h m_sel=%h, required all 0",
                     m_write, m_addr, m_wdata, m_sel);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || grant !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: busy=%b grant=%b, required 0/00", busy, grant);
        end
    endtask

    task automatic test_single_read();
        int got;
        got = -1;
        slave_en    = 1'b1;
        slave_delay = 3;
        set_cmd(0, 1'b0, 8'h1F, 8'h00, 4'h1);
        push_exp(2'b01, 1'b0, 8'h1F);
        req[0] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            checks++;
            if (m_start !== (c == 1)) begin
                errors++;
                $display("FAIL read_start c%0d: m_start=%b, required %b", c, m_start, (c == 1));
            end
            if (c == 1) begin
                checks++;
                if (m_addr !== 8'h1F || m_sel !== 4'h1 || m_write !== 1'b0 || grant !== 2'b01) begin
                    errors++;
                    $display("FAIL read_cmd: addr=%h sel=%h write=%b grant=%b, required 1f/1/0/01",
                             m_addr, m_sel, m_write, grant);
                end
            end
            if (ack[0]) begin
                req[0] = 1'b0;
                got = c;
                break;
            end
        end
        checks++;
        if (got != 5) begin
            errors++;
            $display("FAIL read_latency: ack at cycle %0d, required 5", got);
        end
        checks++;
        if (rdata !== 8'hA5 || err !== 1'b0) begin
            errors++;
            $display("FAIL read_data: rdata=%h err=%b, required a5/0", rdata, err);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || grant !== 2'b00) begin
            errors++;
            $display("FAIL read_after: busy=%b grant=%b, required 0/00", busy, grant);
        end
    endtask

    task automatic test_contention();
        logic [1:0] order [4];
        int k;
        int acks;
        order = '{2'b01, 2'b10, 2'b01, 2'b10};
        k = 0;
        acks = 0;
        rst_n = 1'b0;
        model_rdata = '0;
        tick();
        rst_n = 1'b1;
        slave_delay = 1;
        set_cmd(0, 1'b0, 8'h10, 8'h00, 4'h1);
        set_cmd(1, 1'b0, 8'h20, 8'h00, 4'h2);
        push_exp(2'b01, 1'b0, 8'h10);
        push_exp(2'b10, 1'b0, 8'h20);
        push_exp(2'b01, 1'b0, 8'h10);
        push_exp(2'b10, 1'b0, 8'h20);
        req = 2'b11;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (m_start === 1'b1 && k < 4) begin
                checks++;
                if (grant !== order[k]) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: grant=%b, required %b", k, grant, order[k]);
                end
                k++;
            end
            if (ack !== 2'b00) begin
                checks++;
                if (ack === 2'b11) begin
                    errors++;
                    $display("FAIL rr_ack_onehot: ack=%b, required one-hot", ack);
                end
                acks++;
                if (acks == 4) begin
                    req = 2'b00;
                    break;
                end
            end
        end
        checks++;
        if (acks != 4 || k != 4) begin
            errors++;
            $display("FAIL rr_count: acks=%0d grants=%0d, required 4/4", acks, k);
        end
        tick();
    endtask

    task automatic test_timeout();
        int got;
        logic [7:0] prev;
        got  = -1;
        prev = model_rdata;
        slave_en = 1'b0;
        set_cmd(0, 1'b0, 8'h33, 8'h00, 4'h3);
        push_exp(2'b01, 1'b1, 8'h33);
        req[0] = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (ack[0]) begin
                req[0] = 1'b0;
                got = c;
                break;
            end
        end
        checks++;
        if (got != 10) begin
            errors++;
            $display("FAIL timeout_latency: ack at cycle %0d, required 10", got);
        end
        checks++;
        if (err !== 1'b1 || rdata !== prev) begin
            errors++;
            $display("FAIL timeout_flags: err=%b rdata=%h, required 1/%h", err, rdata, prev);
        end
        tick();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err_clear: err=%b, required 0", err);
        end
        got = -1;
        slave_en    = 1'b1;
        slave_delay = 2;
        set_cmd(1, 1'b0, 8'h70, 8'h00, 4'h7);
        push_exp(2'b10, 1'b0, 8'h70);
        req[1] = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (ack[1]) begin
                req[1] = 1'b0;
                got = c;
                break;
            end
        end
        checks++;
        if (got != 4 || err !== 1'b0 || rdata !== mem[8'h70]) begin
            errors++;
            $display("FAIL timeout_recover: ack cycle %0d err=%b rdata=%h, required 4/0/%h",
                     got, err, rdata, mem[8'h70]);
        end
        tick();
    endtask

    task automatic test_withdraw();
        int got;
        got = -1;
        slave_en    = 1'b1;
        slave_delay = 6;
        set_cmd(0, 1'b0, 8'h50, 8'h00, 4'h5);
        set_cmd(1, 1'b0, 8'h60, 8'h00, 4'h6);
        push_exp(2'b01, 1'b0, 8'h50);
        req[0] = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 3) req[1] = 1'b1;
            if (c == 4) req[1] = 1'b0;
            checks++;
            if (grant[1] !== 1'b0) begin
                errors++;
                $display("FAIL withdraw_grant c%0d: grant=%b, required bit1=0", c, grant);
            end
            if (ack[0]) begin
                req[0] = 1'b0;
                got = c;
                break;
            end
        end
        checks++;
        if (got != 8) begin
            errors++;
            $display("FAIL withdraw_latency: ack at cycle %0d, required 8", got);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (grant !== 2'b00 || busy !== 1'b0) begin
                errors++;
                $display("FAIL withdraw_idle: grant=%b busy=%b, required 00/0", grant, busy);
            end
        end
        got = -1;
        slave_delay = 4;
        set_cmd(0, 1'b0, 8'h51, 8'h00, 4'h5);
        push_exp(2'b01, 1'b0, 8'h51);
        req[0] = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 3) req[0] = 1'b0;
            if (ack[0]) begin
                got = c;
                break;
            end
        end
        checks++;
        if (got != 6) begin
            errors++;
            $display("FAIL drop_after_grant: ack at cycle %0d, required 6", got);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        int done;
        done = 0;
        slave_en = 1'b0;
        set_cmd(0, 1'b0, 8'h30, 8'h00, 4'h3);
        req[0] = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_busy: busy=%b, required 1", busy);
        end
        rst_n = 1'b0;
        model_rdata = '0;
        #1;
        checks++;
        if ({ack, err, rdata, grant, busy, m_start, m_write, m_addr, m_wdata, m_sel} !== '0) begin
            errors++;
            $display("FAIL rst_async: ack=%b err=%b rdata=%h grant=%b busy=%b addr=%h, required all 0",
                     ack, err, rdata, grant, busy, m_addr);
        end
        set_cmd(1, 1'b0, 8'h31, 8'h00, 4'h3);
        req = 2'b11;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (ack !== 2'b00 || grant !== 2'b00) begin
                errors++;
                $display("FAIL rst_hold: ack=%b grant=%b, required 00/00", ack, grant);
            end
        end
        slave_en    = 1'b1;
        slave_delay = 2;
        push_exp(2'b01, 1'b0, 8'h30);
        push_exp(2'b10, 1'b0, 8'h31);
        rst_n = 1'b1;
        tick();
        checks++;
        if (grant !== 2'b01 || m_start !== 1'b1) begin
            errors++;
            $display("FAIL rst_first_grant: grant=%b m_start=%b, required 01/1", grant, m_start);
        end
        for (int c = 0; c < 40; c++) begin
            tick();
            if (ack[0]) req[0] = 1'b0;
            if (ack[1]) begin
                req[1] = 1'b0;
                done = 1;
                break;
            end
        end
        checks++;
        if (done != 1) begin
            errors++;
            $display("FAIL rst_resume: ack[1] seen=%0d, required 1", done);
        end
        tick();
    endtask

    task automatic test_write();
        int got;
        got = -1;
        slave_en    = 1'b1;
        slave_delay = 3;
        set_cmd(1, 1'b1, 8'h44, 8'h3C, 4'h2);
        push_exp(2'b10, 1'b0, 8'h44);
        req[1] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c <= 4) begin
                checks++;
                if (m_write !== 1'b1 || m_wdata !== 8'h3C || m_sel !== 4'h2 || m_addr !== 8'h44) begin
                    errors++;
                    $display("FAIL write_hold c%0d: write=%b wdata=%h sel=%h addr=%h, required 1/3c/2/44",
                             c, m_write, m_wdata, m_sel, m_addr);
                end
            end
            if (ack[1]) begin
                req[1] = 1'b0;
                got = c;
                break;
            end
        end
        checks++;
        if (got != 5) begin
            errors++;
            $display("FAIL write_ack: ack[1] at cycle %0d, required 5", got);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h1F] = 8'hA5;
        model_rdata = '0;
        slave_en    = 1'b0;
        slave_delay = 1;
        rst_n       = 1'b0;
        req         = '0;
        req_write   = '0;
        req_addr    = '0;
        req_wdata   = '0;
        req_sel     = '0;

        test_reset();
        test_single_read();
        test_contention();
        test_timeout();
        test_withdraw();
        test_reset_mid_wait();
        test_write();

        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected acks outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
